sap_core_seq: RTL and testbench

// - Parametrised successor to the fixed 8-bit, 6-beat SAP datapath and its control unit.
// - Single block: beat ring counter, PC, MAR, IR, A/B registers, adder/subtractor, output register and microsequencer.
// - Talks to an external asynchronous-read program/data memory.
// - Adds SUB, JMP, JC and HLT, a run/pause input, a configurable beat count, and widths generalised beyond 8 bits.

---
 rtl/sap_pkg.sv | 42 ++++
 rtl/sap_beat_ring.sv | 23 ++
 rtl/sap_core_seq.sv | 175 +++++++++++++++++
 tb/tb_sap_core_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP core: opcode encodings, beat indices and the
// decoded micro-operation bundle produced by the microsequencer.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JC  = 4'h4;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;

    localparam int NBEAT_MIN = 6;

    // One strobe per register transfer; at most a handful are active per beat.
    typedef struct packed {
        logic ld_mar_pc;
        logic ld_mar_opnd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc_opnd;
        logic ld_a_mem;
        logic ld_b_mem;
        logic alu_add;
        logic alu_sub;
        logic ld_out;
        logic set_halt;
    } ctrl_t;

    // Opcode field must hold 0xF, and the instruction word must split exactly.
    function automatic bit cfg_ok(input int dw, input int aw, input int opw, input int nbeat);
        return (dw == opw + aw) && (aw > 0) && (opw >= 4) && (nbeat >= NBEAT_MIN);
    endfunction

endpackage

// File: rtl/sap_beat_ring.sv
// One-hot beat ring counter; rotates one position per clock unless held.
module sap_beat_ring #(
    parameter int NBEAT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    output logic [NBEAT-1:0] beat
);

    logic [NBEAT-1:0] r_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat <= NBEAT'(1);
        end else if (!hold) begin
            r_beat <= {r_beat[NBEAT-2:0], r_beat[NBEAT-1]};
        end
    end

    assign beat = r_beat;

endmodule

// File: rtl/sap_core_seq.sv
// Parametrised SAP core: fetch/execute microsequencer plus PC, MAR, IR, A, B,
// adder/subtractor and output register, attached to an async-read memory.
module sap_core_seq
    import sap_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int OPW   = 4,
    parameter int NBEAT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_rdata,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    output logic [NBEAT-1:0] beat,
    output logic             carry,
    output logic             halted
);

    generate
        if (!cfg_ok(DW, AW, OPW, NBEAT)) begin : g_cfg_err
            $error("sap_core_seq: inconsistent DW/AW/OPW/NBEAT");
        end
    endgenerate

    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_mar;
    logic [DW-1:0]    r_ir;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_out;
    logic             r_carry;
    logic             r_out_valid;
    logic             r_halted;

    logic [NBEAT-1:0] w_beat;
    logic             w_hold;
    logic             w_adv;
    logic [OPW-1:0]   w_op;
    logic [AW-1:0]    w_opnd;
    logic [DW:0]      w_sum;
    logic [DW:0]      w_diff;
    ctrl_t            w_ctrl;

    // Pausing only at T0 keeps an instruction atomic once its fetch has begun.
    assign w_hold = (w_beat[T0] & ~run) | r_halted;
    assign w_adv  = ~w_hold;

    sap_beat_ring #(
        .NBEAT (NBEAT)
    ) u_ring (
        .clk  (clk),
        .rst  (rst),
        .hold (w_hold),
        .beat (w_beat)
    );

    assign w_op   = r_ir[DW-1:DW-OPW];
    assign w_opnd = r_ir[AW-1:0];
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Microsequencer: beat x opcode -> register-transfer strobes.
    always_comb begin
        w_ctrl = '0;
        if (w_adv) begin
            if (w_beat[T0]) begin
                w_ctrl.ld_mar_pc = 1'b1;
            end
            if (w_beat[T1]) begin
                w_ctrl.ld_ir  = 1'b1;
                w_ctrl.inc_pc = 1'b1;
            end
            if (w_beat[T2]) begin
                case (w_op)
                    OPW'(OP_LDA),
                    OPW'(OP_ADD),
                    OPW'(OP_SUB): w_ctrl.ld_mar_opnd = 1'b1;
                    OPW'(OP_JMP): w_ctrl.ld_pc_opnd  = 1'b1;
                    OPW'(OP_JC):  w_ctrl.ld_pc_opnd  = r_carry;
                    OPW'(OP_OUT): w_ctrl.ld_out      = 1'b1;
                    OPW'(OP_HLT): w_ctrl.set_halt    = 1'b1;
                    default:      ;
                endcase
            end
            if (w_beat[T3]) begin
                case (w_op)
                    OPW'(OP_LDA): w_ctrl.ld_a_mem = 1'b1;
                    OPW'(OP_ADD),
                    OPW'(OP_SUB): w_ctrl.ld_b_mem = 1'b1;
                    default:      ;
                endcase
            end
            if (w_beat[T4]) begin
                case (w_op)
                    OPW'(OP_ADD): w_ctrl.alu_add = 1'b1;
                    OPW'(OP_SUB): w_ctrl.alu_sub = 1'b1;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= '0;
            r_mar <= '0;
            r_ir  <= '0;
        end else begin
            if (w_ctrl.ld_mar_pc) begin
                r_mar <= r_pc;
            end else if (w_ctrl.ld_mar_opnd) begin
                r_mar <= w_opnd;
            end
            if (w_ctrl.ld_ir) begin
                r_ir <= mem_rdata;
            end
            // Natural AW-bit overflow gives the wrap from the top address to 0.
            if (w_ctrl.inc_pc) begin
                r_pc <= r_pc + AW'(1);
            end else if (w_ctrl.ld_pc_opnd) begin
                r_pc <= w_opnd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_ctrl.ld_a_mem) begin
                r_a <= mem_rdata;
            end else if (w_ctrl.alu_add) begin
                r_a     <= w_sum[DW-1:0];
                r_carry <= w_sum[DW];
            end else if (w_ctrl.alu_sub) begin
                // Carry doubles as no-borrow: set when A >= B unsigned.
                r_a     <= w_diff[DW-1:0];
                r_carry <= ~w_diff[DW];
            end
            if (w_ctrl.ld_b_mem) begin
                r_b <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= w_ctrl.ld_out;
            if (w_ctrl.ld_out) begin
                r_out <= r_a;
            end
            if (w_ctrl.set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign mem_addr  = r_mar;
    assign out_data  = r_out;
    assign out_valid = r_out_valid;
    assign beat      = w_beat;
    assign carry     = r_carry;
    assign halted    = r_halted;

endmodule

// File: tb/tb_sap_core_seq.sv
// Directed bench for sap_core_seq: scoreboarded OUT values plus flag, address
// and beat checks; a second NBEAT=8 instance runs the base program in parallel.
module tb_sap_core_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b1;

    logic [3:0] mem_addr, mem_addr8;
    logic [7:0] mem_rdata, mem_rdata8;
    logic [7:0] out_data, out_data8;
    logic       out_valid, out_valid8;
    logic [5:0] beat;
    logic [7:0] beat8;
    logic       carry, carry8;
    logic       halted, halted8;

    logic [7:0] mem  [16];
    logic [7:0] mem8 [16];

    int         total = 0;
    int         bad   = 0;
    int         cyc;
    logic [7:0] exp_q [$];
    int         ov_cnt, ov_cyc, ov8_cnt, ov8_cyc;
    logic [7:0] ov8_val;
    logic       prev_ov;

    always #5 clk = ~clk;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata8 = mem8[mem_addr8];

    sap_core_seq #(.DW(8), .AW(4), .OPW(4), .NBEAT(6)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid),
        .beat(beat), .carry(carry), .halted(halted)
    );

    sap_core_seq #(.DW(8), .AW(4), .OPW(4), .NBEAT(8)) dut8 (
        .clk(clk), .rst(rst), .run(1'b1),
        .mem_addr(mem_addr8), .mem_rdata(mem_rdata8),
        .out_data(out_data8), .out_valid(out_valid8),
        .beat(beat8), .carry(carry8), .halted(halted8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Scoreboard monitor: every out_valid pops one expected value.
    always @(negedge clk) begin
        if (!rst) begin
            ov_cnt  <= 0;
            ov8_cnt <= 0;
            prev_ov <= 1'b0;
        end else begin
            if (prev_ov) chk("ov_single_cycle", out_valid, 0);
            if (out_valid) begin
                ov_cnt <= ov_cnt + 1;
                ov_cyc <= cyc;
                chk("sb_has_entry", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
                $display("txn: out_data=%02h at cycle %0d", out_data, cyc);
            end
            prev_ov <= out_valid;
            if (out_valid8) begin
                ov8_cnt <= ov8_cnt + 1;
                ov8_cyc <= cyc;
                ov8_val <= out_data8;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h50;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[9] = 8'h05; mem[10] = 8'h03;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, halted, 1);
        @(negedge clk);
    endtask

    task automatic wait_t1(input int budget, input string tag);
        int n = 1;
        @(negedge clk);
        while (!beat[1] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, beat[1], 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem8[i] = 8'h50;
        mem8[0] = 8'h09; mem8[1] = 8'h1A; mem8[2] = 8'hE0; mem8[3] = 8'hF0;
        mem8[9] = 8'h05; mem8[10] = 8'h03;
        load_prog1();

        // Reset state.
        @(negedge clk);
        chk("rst_beat", beat, 6'h01);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry", carry, 0);
        chk("rst_halted", halted, 0);

        // Base program: 5 + 3 = 8, both beat counts.
        exp_q.push_back(8'h08);
        rst = 1'b1;
        wait_halt(100, "p1_halt");
        chk("p1_ov_cnt", ov_cnt, 1);
        chk("p1_ov_cycle", ov_cyc, 15);
        chk("p1_carry", carry, 0);
        chk("p1_beat_frozen", beat, 6'h08);
        chk("p1_halt_addr", mem_addr, 3);
        n = 0;
        while (!halted8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("nb8_halt", halted8, 1);
        chk("nb8_out", ov8_val, 8'h08);
        chk("nb8_ov_cnt", ov8_cnt, 1);
        chk("nb8_ov_cycle", ov8_cyc, 19);
        chk("nb8_beat_frozen", beat8, 8'h08);
        chk("nb8_carry", carry8, 0);

        // Asynchronous reset while halted.
        rst = 1'b0;
        #1;
        chk("hrst_beat", beat, 6'h01);
        chk("hrst_halted", halted, 0);
        chk("hrst_out_data", out_data, 0);
        chk("hrst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of the ADD's T3, then a clean rerun.
        n = 0;
        while (!(beat[3] && mem_addr == 4'hA) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("mrst_reach_t3", beat[3], 1);
        rst = 1'b0;
        #1;
        chk("mrst_beat", beat, 6'h01);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_halted", halted, 0);
        @(negedge clk);
        exp_q.push_back(8'h08);
        rst = 1'b1;
        wait_halt(100, "mrst_halt");
        chk("mrst_ov_cnt", ov_cnt, 1);
        chk("mrst_halt_addr", mem_addr, 3);

        // Pause requested during T2 of ADD.
        exp_q.push_back(8'h08);
        do_reset();
        n = 0;
        while (!(beat[2] && mem_addr == 4'h1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("pause_reach_t2", beat[2], 1);
        run = 1'b0;
        repeat (14) @(negedge clk);
        chk("pause_beat", beat, 6'h01);
        chk("pause_mem_addr", mem_addr, 4'hA);
        chk("pause_no_out", ov_cnt, 0);
        run = 1'b1;
        @(negedge clk);
        chk("resume_beat", beat, 6'h02);
        chk("resume_mem_addr", mem_addr, 2);
        wait_halt(100, "pause_halt");
        chk("pause_ov_cnt", ov_cnt, 1);

        // ADD with carry out, then JC taken to 6.
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h19; mem[2] = 8'h46; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[6] = 8'hE0; mem[7] = 8'hF0; mem[8] = 8'hF0; mem[9] = 8'h20;
        exp_q.push_back(8'h10);
        do_reset();
        wait_halt(120, "jc_t_halt");
        chk("jc_t_carry", carry, 1);
        chk("jc_t_halt_addr", mem_addr, 7);

        // No carry: JC falls through.
        mem[8] = 8'h01; mem[9] = 8'h02;
        exp_q.push_back(8'h03);
        do_reset();
        wait_halt(120, "jc_n_halt");
        chk("jc_n_carry", carry, 0);
        chk("jc_n_halt_addr", mem_addr, 4);

        // SUB with borrow, then equal operands; JMP skips address 4.
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h29; mem[2] = 8'hE0; mem[3] = 8'h35; mem[4] = 8'hF0;
        mem[5] = 8'hF0; mem[8] = 8'h03; mem[9] = 8'h05;
        exp_q.push_back(8'hFE);
        do_reset();
        wait_halt(120, "sub_b_halt");
        chk("sub_b_carry", carry, 0);
        chk("sub_b_halt_addr", mem_addr, 5);
        mem[8] = 8'h05;
        exp_q.push_back(8'h00);
        do_reset();
        wait_halt(120, "sub_e_halt");
        chk("sub_e_carry", carry, 1);
        chk("sub_e_halt_addr", mem_addr, 5);

        // PC wrap: JMP F, NOP at F, then fetches from 0 and 1.
        clear_mem();
        mem[0] = 8'h3F;
        do_reset();
        n = 0;
        while (!(beat[1] && mem_addr == 4'hF) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_fetch_f", mem_addr, 4'hF);
        mem[0] = 8'h50; mem[1] = 8'hF0;
        wait_t1(20, "wrap_t1_a");
        chk("wrap_fetch_0", mem_addr, 0);
        wait_t1(20, "wrap_t1_b");
        chk("wrap_fetch_1", mem_addr, 1);
        wait_halt(40, "wrap_halt");
        chk("wrap_halt_addr", mem_addr, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
